// File: rtl/gb_capture_if.sv
// Frame-buffer write bus produced by the Game Boy capture stage.
// master: the capture stage (drives writes); slave: the frame buffer.
interface gb_capture_if #(
  parameter int unsigned ADDR_W = 15
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic              frame_start;
  logic              frame_done;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output frame_start,
    output frame_done
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input frame_start,
    input frame_done
  );

endinterface

// File: rtl/gb_capture.sv
// Game Boy LCD tap capture: synchronises pixclk/hsync/vsync/gb_d into clk, tracks the
// pixel position and issues one frame-buffer write (linear address + shade) per pixel.
module gb_capture #(
  parameter int unsigned H_PIXELS    = 160,
  parameter int unsigned V_LINES     = 144,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pixclk_i,
  input  logic         hsync_i,
  input  logic         vsync_i,
  input  logic [1:0]   gb_d_i,
  input  logic         err_clr_i,
  gb_capture_if.master wr_if,
  output logic         line_err_o,
  output logic         ovf_err_o
);

  localparam int unsigned XW = $clog2(H_PIXELS + 1);
  localparam int unsigned YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]     XMax     = XW'(H_PIXELS);
  localparam logic [YW-1:0]     YMax     = YW'(V_LINES);
  localparam logic [ADDR_W-1:0] HStep    = ADDR_W'(H_PIXELS);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(H_PIXELS * V_LINES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Synchronisers
  logic [SYNC_STAGES-1:0]      pix_sync_q, hs_sync_q, vs_sync_q;
  logic [SYNC_STAGES-1:0][1:0] d_sync_q;
  logic                        pix_s, hs_s, vs_s;
  logic [1:0]                  d_s;

  // Registered pixel event with the side signals sampled alongside it
  logic       pix_prev_q;
  logic       ev_q, ev_hs_q, ev_vs_q;
  logic [1:0] ev_d_q;

  // Position tracking; x_q counts pixels seen on the current line
  state_e            state_q;
  logic [XW-1:0]     x_q, x_inc;
  logic [YW-1:0]     y_q, y_inc;
  logic [ADDR_W-1:0] base_q, base_next, pix_addr;
  logic              pix_ok, line_ok;

  // Registered outputs
  logic              wr_en_q, fs_q, fd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        data_q;
  logic              line_err_q, ovf_err_q;

  assign pix_s = pix_sync_q[SYNC_STAGES-1];
  assign hs_s  = hs_sync_q[SYNC_STAGES-1];
  assign vs_s  = vs_sync_q[SYNC_STAGES-1];
  assign d_s   = d_sync_q[SYNC_STAGES-1];

  // Shift the asynchronous inputs through the synchroniser chains
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_sync_q <= '0;
      hs_sync_q  <= '0;
      vs_sync_q  <= '0;
      d_sync_q   <= '0;
    end else begin
      pix_sync_q <= {pix_sync_q[SYNC_STAGES-2:0], pixclk_i};
      hs_sync_q  <= {hs_sync_q[SYNC_STAGES-2:0], hsync_i};
      vs_sync_q  <= {vs_sync_q[SYNC_STAGES-2:0], vsync_i};
      d_sync_q   <= {d_sync_q[SYNC_STAGES-2:0], gb_d_i};
    end
  end

  // Detect pixclk falling edges and latch hsync/vsync/shade from the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_prev_q <= 1'b0;
      ev_q       <= 1'b0;
      ev_hs_q    <= 1'b0;
      ev_vs_q    <= 1'b0;
      ev_d_q     <= '0;
    end else begin
      pix_prev_q <= pix_s;
      ev_q       <= pix_prev_q & ~pix_s;
      ev_hs_q    <= hs_s;
      ev_vs_q    <= vs_s;
      ev_d_q     <= d_s;
    end
  end

  // Saturating position increments and candidate write addresses
  always_comb begin
    x_inc     = (x_q == XMax) ? x_q : x_q + XW'(1);
    y_inc     = (y_q == YMax) ? y_q : y_q + YW'(1);
    pix_ok    = (x_q != XMax) && (y_q != YMax);
    line_ok   = (y_inc != YMax);
    base_next = base_q + HStep;
    pix_addr  = base_q + ADDR_W'(x_q);
  end

  // Capture FSM: position tracking, write generation and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      wr_en_q    <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      line_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      // Clear first so a coincident new error below takes priority
      if (err_clr_i) begin
        line_err_q <= 1'b0;
        ovf_err_q  <= 1'b0;
      end
      if (ev_q) begin
        data_q <= ev_d_q;
        case (state_q)
          StIdle: begin
            if (ev_hs_q && ev_vs_q) begin
              state_q <= StRun;
              x_q     <= XW'(1);
              y_q     <= '0;
              base_q  <= '0;
              wr_en_q <= 1'b1;
              addr_q  <= '0;
              fs_q    <= 1'b1;
              fd_q    <= (LastAddr == '0);
            end
          end
          StRun: begin
            if (ev_hs_q) begin
              if (x_q != XMax) line_err_q <= 1'b1;
              x_q <= XW'(1);
              if (ev_vs_q) begin
                y_q     <= '0;
                base_q  <= '0;
                wr_en_q <= 1'b1;
                addr_q  <= '0;
                fs_q    <= 1'b1;
                fd_q    <= (LastAddr == '0);
              end else begin
                y_q <= y_inc;
                if (line_ok) begin
                  base_q  <= base_next;
                  wr_en_q <= 1'b1;
                  addr_q  <= base_next;
                  fd_q    <= (base_next == LastAddr);
                end else begin
                  ovf_err_q <= 1'b1;
                end
              end
            end else begin
              x_q <= x_inc;
              if (pix_ok) begin
                wr_en_q <= 1'b1;
                addr_q  <= pix_addr;
                fd_q    <= (pix_addr == LastAddr);
              end else begin
                ovf_err_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign wr_if.wr_en       = wr_en_q;
  assign wr_if.wr_addr     = addr_q;
  assign wr_if.wr_data     = data_q;
  assign wr_if.frame_start = fs_q;
  assign wr_if.frame_done  = fd_q;
  assign line_err_o        = line_err_q;
  assign ovf_err_o         = ovf_err_q;

endmodule

// File: tb/tb_gb_capture.sv
// Self-checking bench for gb_capture, run with a reduced 20x10 frame so whole frames
// stay short. Expected writes come from a position/arithmetic model of the capture rules.
module tb_gb_capture;

  localparam int unsigned H  = 20;
  localparam int unsigned V  = 10;
  localparam int unsigned SS = 2;
  localparam int unsigned AW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixclk = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [1:0] gb_d = 2'b00;
  logic       err_clr = 1'b0;
  logic       line_err, ovf_err;

  gb_capture_if #(.ADDR_W(AW)) wr_if ();

  gb_capture #(
    .H_PIXELS   (H),
    .V_LINES    (V),
    .SYNC_STAGES(SS),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pixclk_i  (pixclk),
    .hsync_i   (hsync),
    .vsync_i   (vsync),
    .gb_d_i    (gb_d),
    .err_clr_i (err_clr),
    .wr_if     (wr_if),
    .line_err_o(line_err),
    .ovf_err_o (ovf_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: Game Boy position as (row, pixels seen on row)
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    data;
    logic          fs;
    logic          fd;
  } wr_t;

  wr_t exp_q[$];
  bit  m_idle = 1'b1;
  int  m_row = 0;
  int  m_col = 0;
  bit  m_line_err = 1'b0;
  bit  m_ovf = 1'b0;

  task automatic model_ev(input bit hs, input bit vs, input bit [1:0] d);
    int  a;
    wr_t e;
    if (m_idle) begin
      if (!(hs && vs)) return;
      m_idle = 1'b0;
      m_col  = H;
    end
    if (hs) begin
      if (m_col != H) m_line_err = 1'b1;
      m_row = vs ? 0 : ((m_row < V) ? m_row + 1 : V);
      m_col = 0;
    end
    if (m_row < V && m_col < H) begin
      a      = m_row * H + m_col;
      e.addr = AW'(a);
      e.data = d;
      e.fs   = (a == 0);
      e.fd   = (a == H * V - 1);
      exp_q.push_back(e);
    end else begin
      m_ovf = 1'b1;
    end
    if (m_col < H) m_col++;
  endtask

  // Write monitor / scoreboard
  int            n_wr = 0;
  int            n_fs = 0;
  int            n_fd = 0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (wr_if.wr_en) begin
        n_wr++;
        if (wr_if.frame_start) n_fs++;
        if (wr_if.frame_done) n_fd++;
        last_addr = wr_if.wr_addr;
        check("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", wr_if.wr_addr, e.addr);
          check("wr_data", wr_if.wr_data, e.data);
          check("frame_start", wr_if.frame_start, e.fs);
          check("frame_done", wr_if.frame_done, e.fd);
        end
      end else if (wr_if.frame_start || wr_if.frame_done) begin
        check("strobe_without_wr_en", {wr_if.frame_start, wr_if.frame_done}, 0);
      end
    end
  end

  // One Game Boy pixel: 200 ns period, data set 5 ns before rise and held 95 ns past fall
  task automatic pixel(input bit hs, input bit vs, input bit [1:0] d);
    hsync = hs;
    vsync = vs;
    gb_d  = d;
    #5 pixclk = 1'b1;
    #100 pixclk = 1'b0;
    model_ev(hs, vs, d);
    #95;
  endtask

  task automatic send_line(input bit vs, input int npix, input bit rnd);
    for (int x = 0; x < npix; x++) begin
      pixel(x == 0, vs && (x == 0), rnd ? 2'($urandom) : 2'(x));
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    #20 err_clr = 1'b0;
    m_line_err = 1'b0;
    m_ovf      = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_line_err"}, line_err, m_line_err);
    check({tag, "_ovf_err"}, ovf_err, m_ovf);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, wr_if.wr_en, 0);
    check({tag, "_wr_addr"}, wr_if.wr_addr, 0);
    check({tag, "_wr_data"}, wr_if.wr_data, 0);
    check({tag, "_frame_start"}, wr_if.frame_start, 0);
    check({tag, "_frame_done"}, wr_if.frame_done, 0);
    check({tag, "_line_err"}, line_err, 0);
    check({tag, "_ovf_err"}, ovf_err, 0);
  endtask

  initial begin
    int  n_wr0, n_fs0, n_fd0, lat;
    bit  seen;
    int  nlines;

    // Reset (edges of async inputs kept off the clk edges)
    #3;
    repeat (3) @(posedge clk);
    #3;
    check_all_zero("reset");
    rst = 1'b0;

    // Start mid-frame: lines without vsync produce nothing
    n_wr0 = n_wr;
    for (int l = 0; l < 3; l++) send_line(1'b0, H, 1'b1);
    check("midframe_no_writes", n_wr - n_wr0, 0);
    check_flags("midframe");

    // Latency: vsync pixel, shade 2, fall placed just after a clk edge
    n_wr0 = n_wr;
    n_fs0 = n_fs;
    n_fd0 = n_fd;
    hsync = 1'b1;
    vsync = 1'b1;
    gb_d  = 2'b10;
    #5 pixclk = 1'b1;
    #100;
    @(posedge clk);
    #1 pixclk = 1'b0;
    model_ev(1'b1, 1'b1, 2'b10);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (wr_if.wr_en) seen = 1'b1;
    end
    check("latency_clks", lat, SS + 2);
    check("latency_addr", wr_if.wr_addr, 0);
    check("latency_data", wr_if.wr_data, 2'b10);
    check("latency_frame_start", wr_if.frame_start, 1);
    #(95 - 10 * lat);

    // Full frame with gb_d = x[1:0]
    for (int x = 1; x < H; x++) pixel(1'b0, 1'b0, 2'(x));
    for (int l = 1; l < V; l++) send_line(1'b0, H, 1'b0);
    check("full_frame_writes", n_wr - n_wr0, H * V);
    check("full_frame_starts", n_fs - n_fs0, 1);
    check("full_frame_dones", n_fd - n_fd0, 1);
    check("full_frame_last_addr", last_addr, H * V - 1);
    check_drained("full_frame");
    check_flags("full_frame");

    // Short line 3, then line 4 begins at 4*H
    send_line(1'b1, H, 1'b1);
    send_line(1'b0, H, 1'b1);
    send_line(1'b0, H, 1'b1);
    send_line(1'b0, H - 5, 1'b1);
    check("short_line_no_err_yet", line_err, 0);
    pixel(1'b1, 1'b0, 2'($urandom));
    check("short_line_err", line_err, 1);
    check("short_line_next_addr", last_addr, 4 * H);
    pulse_err_clr();
    check("short_line_err_cleared", line_err, 0);
    for (int x = 1; x < H; x++) pixel(1'b0, 1'b0, 2'($urandom));
    for (int l = 5; l < V; l++) send_line(1'b0, H, 1'b1);
    check_flags("short_line");
    check_drained("short_line");

    // Overflow: over-long line, then an extra line past the last
    n_wr0 = n_wr;
    send_line(1'b1, H + 5, 1'b1);
    check("overflow_line_writes", n_wr - n_wr0, H);
    check("overflow_flag", ovf_err, 1);
    for (int l = 1; l < V; l++) send_line(1'b0, H, 1'b1);
    n_wr0 = n_wr;
    send_line(1'b0, H, 1'b1);
    check("extra_line_writes", n_wr - n_wr0, 0);
    check("extra_line_ovf_sticky", ovf_err, 1);
    check_flags("overflow");
    pulse_err_clr();
    check_flags("overflow_cleared");

    // Randomised frames: line lengths and line counts around nominal
    for (int f = 0; f < 5; f++) begin
      nlines = $urandom_range(V - 1, V + 1);
      for (int l = 0; l < nlines; l++) begin
        send_line(l == 0, $urandom_range(H - 2, H + 2), 1'b1);
      end
      check_flags("random_frame");
      check_drained("random_frame");
      if ($urandom_range(0, 1) == 1) begin
        pulse_err_clr();
        check_flags("random_clear");
      end
    end

    // Reset mid-frame
    for (int l = 0; l < 6; l++) send_line(l == 0, H + (l == 2 ? 3 : 0), 1'b1);
    check_drained("pre_reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midframe_reset");
    m_idle     = 1'b1;
    m_line_err = 1'b0;
    m_ovf      = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    n_wr0 = n_wr;
    n_fs0 = n_fs;
    for (int l = 6; l < V; l++) send_line(1'b0, H, 1'b1);
    check("after_reset_no_writes", n_wr - n_wr0, 0);
    pixel(1'b1, 1'b1, 2'($urandom));
    check("after_reset_first_addr", last_addr, 0);
    check("after_reset_frame_start", n_fs - n_fs0, 1);
    check("after_reset_writes", n_wr - n_wr0, 1);
    check_drained("after_reset");
    check_flags("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_capture.md
Name: gb_capture

Overview:
- Front-end capture stage for the Game Boy LCD tap: receives the Game Boy's asynchronous pixclk/hsync/vsync/gb_d signals, which are not synchronous to clk.
- Synchronises them into the clk domain and counts pixel/line positions.
- Emits one frame-buffer write per Game Boy pixel: linear address plus 2-bit shade.
- Feeds the frame buffer that the LCD write engine later scans out.

Parameters:
- H_PIXELS, 160, active pixels per line.
- V_LINES, 144, active lines per frame.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).
- ADDR_W, 15, width of wr_addr; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous, active-high reset.
- pixclk  input  1  Game Boy pixel clock, asynchronous.
- hsync  input  1  Game Boy line sync, asynchronous; high during first pixel of each line.
- vsync  input  1  Game Boy frame sync, asynchronous; high throughout line 0.
- gb_d  input  2  pixel shade, asynchronous; stable from 5 ns before pixclk rise to 95 ns after pixclk fall.
- err_clr  input  1  clears sticky error flags.
- wr_en  output  1  one-clk write strobe.
- wr_addr  output  ADDR_W  y*H_PIXELS + x.
- wr_data  output  2  captured shade.
- frame_start  output  1  one-clk pulse when pixel (0,0) is written.
- frame_done  output  1  one-clk pulse when pixel (H_PIXELS-1, V_LINES-1) is written.
- line_err  output  1  sticky; a line ended with x != H_PIXELS.
- ovf_err  output  1  sticky; a pixel was dropped because x or y was out of range.

Behaviour:
- Synchronisation: pixclk, hsync, vsync and gb_d each pass through SYNC_STAGES flops. One further flop on pixclk_s provides edge detection.
- Pixel event: a pixclk_s falling edge (prev=1, cur=0). At the event, sample the synchronised hsync, vsync and gb_d from the same clk cycle. Data is stable by then because it has been stable for at least 100 ns before the fall.
- Rising edges of pixclk are ignored.
- State machine:
  - IDLE, entered on reset:
    - Events with hsync_s=0 or vsync_s=0 are discarded; no write and no error.
    - An event with hsync_s=1 and vsync_s=1 means x=0, y=0: write pixel, pulse frame_start, go to RUN.
  - RUN:
    - Event with hsync_s=1, vsync_s=1: new frame. If the previous line had x != H_PIXELS, set line_err. Set y=0, x=0, write pixel, pulse frame_start.
    - Event with hsync_s=1, vsync_s=0: new line. If previous x != H_PIXELS, set line_err. Set y=y+1, x=0. Write only if the new y < V_LINES; otherwise drop and set ovf_err.
    - Event with hsync_s=0: x=x+1. Write if x < H_PIXELS and y < V_LINES; otherwise drop and set ovf_err.
    - x saturates at H_PIXELS; y saturates at V_LINES; no wrap-around.
- Address generation:
  - line_base register: cleared on frame start, += H_PIXELS on line start.
  - wr_addr = line_base + x.
  - No multiplier.
- Output timing:
  - wr_en, wr_addr, wr_data, frame_start and frame_done are registered.
  - They are asserted exactly 1 clk after the cycle in which the falling edge is detected.
  - Total latency from pixclk fall to wr_en is SYNC_STAGES+2 clk.
- frame_done asserts together with wr_en for the write at address H_PIXELS*V_LINES-1.
- Sticky errors:
  - line_err and ovf_err are set by their conditions and cleared by err_clr.
  - If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- Reset values:
  - All outputs are 0.
  - State is IDLE; x, y and line_base are 0.
  - Synchroniser flops are 0, so a pixclk held high at reset release produces no event until it falls.
- Reset mid-frame: all capture is abandoned and the block returns to IDLE. The next write is pixel (0,0) of the following frame.
- Only one event can occur per pixclk period (200 ns = 10 clk), so wr_en is never asserted on consecutive clks.

Test Plan:
- Full frame: 144 lines × 160 pixels, 200 ns pixclk period, gb_d = x[1:0] -> exactly 23040 wr_en pulses, addresses 0..23039 in order, wr_data matches. One frame_start at addr 0, one frame_done at addr 23039, both error flags 0.
- Latency: single pixclk fall with hsync=vsync=1, gb_d=2'b10 -> wr_en high exactly 4 clk after the fall (SYNC_STAGES=2), wr_addr=0, wr_data=2'b10.
- Start mid-frame: release reset, begin at line 50 without vsync -> no writes until the next vsync line, then the first write is at addr 0.
- Short line: line 3 with 150 pixels, then hsync -> line_err=1, and line 4's first write is at addr 640. Pulse err_clr -> line_err=0.
- Overflow: line with 165 pixels -> 160 writes, 5 drops, ovf_err=1. A 145th line -> no writes, ovf_err stays 1.
- Reset mid-frame: assert rst at line 70 -> all outputs 0 the next clk. After release, no writes until vsync; the first subsequent write is addr 0 with frame_start.
